elevator_request_queue: RTL and testbench
=========================================

ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 1..15, is the number of consecutive stable-high synchronized samples needed to accept a press.
REQ-002 The design SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  elevator base clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 outside_up  input  6  raw hall up buttons, bit i = floor i, asynchronous level.
REQ-006 outside_down  input  6  raw hall down buttons, bit i = floor i.
REQ-007 inside_floor  input  6  raw cabin floor buttons, bit i = floor i.
REQ-008 serve_valid  input  1  one-cycle strobe from the controller: a floor has been serviced.
REQ-009 serve_floor  input  3  serviced floor index, 0..5.
REQ-010 serve_dir  input  2  00 clear inside only; 01 up+inside; 10 down+inside; 11 up+down+inside.
REQ-011 queue_up  output  6  pending hall up requests, registered.
REQ-012 queue_down  output  6  pending hall down requests, registered.
REQ-013 queue_inside  output  6  pending cabin requests, registered.
REQ-014 req_count  output  5  popcount of the three queues, registered.
REQ-015 any_request  output  1  high when req_count is nonzero.
REQ-016 queue_changed  output  1  one-cycle pulse when any queue bit changed on the previous edge.

Function
REQ-017 Each of the 18 button inputs SHALL pass through its own two-flop synchronizer before any other use.
REQ-018 Each button SHALL have a 4-bit stable counter: it increments while the synchronized level is 1 and saturates at DEBOUNCE_CYCLES, and it clears to 0 whenever the synchronized level is 0.
REQ-019 A press SHALL be accepted exactly once, on the edge where the counter reaches DEBOUNCE_CYCLES. A further press on the same button requires at least one synchronized-low sample in between.
REQ-020 Latency: the raw input first sampled high at edge k and held high SHALL be visible on the queue bit after edge k+DEBOUNCE_CYCLES+2.
REQ-021 Presses on an invalid direction SHALL be discarded and never set a bit. The invalid directions are outside_up[5] (top floor) and outside_down[0] (ground floor). queue_up[5] and queue_down[0] SHALL stay 0.
REQ-022 An accepted press SHALL set its queue bit. Setting a bit that is already set SHALL be a no-op: no pulse and no count change.
REQ-023 When serve_valid=1 and serve_floor<=5, the bits at serve_floor SHALL be cleared on that edge. queue_inside is always cleared; queue_up and queue_down are cleared per serve_dir.
REQ-024 If serve_valid=1 and serve_floor>5, the serve SHALL be ignored entirely.
REQ-025 If an accepted press and a serve clear hit the same bit on the same edge, the clear SHALL win and the bit SHALL end at 0. Presses on other bits SHALL still take effect.
REQ-026 Multiple presses accepted on the same edge SHALL all be applied on that edge.
REQ-027 req_count and any_request SHALL reflect the queue contents after the same edge; there is no additional latency.
REQ-028 queue_changed SHALL be 1 in the cycle after the edge on which any of the 18 queue bits toggled, and 0 otherwise.
REQ-029 No input sequence SHALL make req_count exceed 16. The 5-bit width SHALL never overflow.

Reset
REQ-030 While rst_n=0 at a rising edge, the following SHALL all clear to 0: synchronizers, stable counters, press-armed state, all queues, req_count, any_request and queue_changed.
REQ-031 Reset SHALL take priority over presses and serves on the same edge.
REQ-032 A button held high across reset deassertion SHALL be treated as a new press. It is accepted DEBOUNCE_CYCLES+2 edges after the first edge with rst_n=1.

Verification
REQ-033 With DEBOUNCE_CYCLES=4, raise outside_up[1] at edge 0 and hold it -> queue_up=6'b000010 after edge 6, req_count=1, any_request=1, queue_changed pulses one cycle; no further change while the button stays held.
REQ-034 Pulse inside_floor[3] high for 3 cycles, then low -> queue_inside is unchanged and req_count=0.
REQ-035 Press outside_up[5] and outside_down[0] and hold both for 20 cycles -> queue_up=0, queue_down=0, queue_changed never asserts.
REQ-036 With queue_up=6'b000100, queue_down=6'b000100 and queue_inside=6'b000100 set, apply serve_valid=1, serve_floor=2, serve_dir=01 -> queue_up=0, queue_inside=0, queue_down=6'b000100, req_count=1.
REQ-037 Arrange for inside_floor[4] to be accepted on the same edge as a serve of floor 4 with serve_dir=00 -> queue_inside[4]=0. Also serve_floor=7 -> no change.
REQ-038 Fill all 16 valid bits -> req_count=16. Then assert rst_n=0 for one edge -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/elevator_request_queue_if.sv
// Button, serve and queue-status bundle between the hall/cabin panel, the
// elevator controller and the request queue.
interface elevator_request_queue_if;
  logic [5:0] outside_up;
  logic [5:0] outside_down;
  logic [5:0] inside_floor;
  logic       serve_valid;
  logic [2:0] serve_floor;
  logic [1:0] serve_dir;
  logic [5:0] queue_up;
  logic [5:0] queue_down;
  logic [5:0] queue_inside;
  logic [4:0] req_count;
  logic       any_request;
  logic       queue_changed;

  modport master (
    output outside_up, outside_down, inside_floor,
    output serve_valid, serve_floor, serve_dir,
    input  queue_up, queue_down, queue_inside,
    input  req_count, any_request, queue_changed
  );

  modport slave (
    input  outside_up, outside_down, inside_floor,
    input  serve_valid, serve_floor, serve_dir,
    output queue_up, queue_down, queue_inside,
    output req_count, any_request, queue_changed
  );
endinterface

// File: rtl/elevator_request_queue.sv
// Elevator request queue: synchronizes and debounces 18 raw buttons, latches
// accepted presses into up/down/cabin queues and clears them on serve strobes.
module elevator_request_queue #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  elevator_request_queue_if.slave bus
);
  localparam int            NB         = 18;
  localparam logic [3:0]    DB_MAX     = 4'(DEBOUNCE_CYCLES);
  // Bit order {inside, down, up}; hall up at the top floor and hall down at
  // the ground floor are physically meaningless and never reach the queues.
  localparam logic [NB-1:0] VALID_MASK = {6'b111111, 6'b111110, 6'b011111};

  logic [NB-1:0] raw;
  logic [NB-1:0] sync_p0;
  logic [NB-1:0] sync_p1;
  logic [3:0]    stable_cnt [NB];
  logic [NB-1:0] fired;
  logic [NB-1:0] matured;
  logic [NB-1:0] accept;

  logic [5:0] q_up;
  logic [5:0] q_down;
  logic [5:0] q_inside;
  logic [5:0] up_next;
  logic [5:0] down_next;
  logic [5:0] inside_next;
  logic [5:0] clr_up;
  logic [5:0] clr_down;
  logic [5:0] clr_inside;
  logic [4:0] count;
  logic       any;
  logic       changed;

  function automatic logic [4:0] popcount18(input logic [NB-1:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) begin
      s = s + 5'(v[i]);
    end
    return s;
  endfunction

  assign raw = {bus.inside_floor, bus.outside_down, bus.outside_up};

  // A button matures once its counter has sat at the threshold; fired keeps it
  // from re-accepting until a synchronized low sample is seen.
  always_comb begin
    matured = '0;
    for (int i = 0; i < NB; i++) begin
      matured[i] = (stable_cnt[i] == DB_MAX) && !fired[i];
    end
    accept = matured & VALID_MASK;
  end

  always_comb begin
    clr_up     = '0;
    clr_down   = '0;
    clr_inside = '0;
    if (bus.serve_valid && (bus.serve_floor < 3'd6)) begin
      clr_inside = 6'b000001 << bus.serve_floor;
      if (bus.serve_dir[0]) clr_up   = 6'b000001 << bus.serve_floor;
      if (bus.serve_dir[1]) clr_down = 6'b000001 << bus.serve_floor;
    end
  end

  // Clear wins over a same-edge press on the same bit.
  assign up_next     = (q_up     | accept[5:0])   & ~clr_up;
  assign down_next   = (q_down   | accept[11:6])  & ~clr_down;
  assign inside_next = (q_inside | accept[17:12]) & ~clr_inside;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      fired    <= '0;
      for (int i = 0; i < NB; i++) begin
        stable_cnt[i] <= '0;
      end
      q_up     <= '0;
      q_down   <= '0;
      q_inside <= '0;
      count    <= '0;
      any      <= 1'b0;
      changed  <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchronizer
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // debounce on the synchronized level
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i]) begin
          if (stable_cnt[i] != DB_MAX) stable_cnt[i] <= stable_cnt[i] + 4'd1;
        end else begin
          stable_cnt[i] <= '0;
        end
      end
      fired    <= sync_p1 & (fired | matured);
      // queue update and status derived from the same next state
      q_up     <= up_next;
      q_down   <= down_next;
      q_inside <= inside_next;
      count    <= popcount18({inside_next, down_next, up_next});
      any      <= |{inside_next, down_next, up_next};
      changed  <= {inside_next, down_next, up_next} != {q_inside, q_down, q_up};
    end
  end

  assign bus.queue_up      = q_up;
  assign bus.queue_down    = q_down;
  assign bus.queue_inside  = q_inside;
  assign bus.req_count     = count;
  assign bus.any_request   = any;
  assign bus.queue_changed = changed;
endmodule

// File: tb/tb_elevator_request_queue.sv
// Scenario bench for elevator_request_queue with a run-length based reference model.
module tb_elevator_request_queue;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  elevator_request_queue_if bus();

  elevator_request_queue #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a press is accepted at edge e when the raw input's run
  // of consecutive high samples ending at edge e-3 is exactly D long.
  int         run_len [18];
  int         hist    [18][3];
  logic [5:0] m_up, m_down, m_in;
  logic [4:0] m_count;
  logic       m_any, m_changed;

  initial begin
    for (int b = 0; b < 18; b++) begin
      run_len[b] = 0;
      for (int j = 0; j < 3; j++) hist[b][j] = 0;
    end
    m_up = '0; m_down = '0; m_in = '0; m_count = '0; m_any = 0; m_changed = 0;
  end

  always @(posedge clk) begin : model
    logic [17:0] raw_v;
    logic [17:0] acc;
    logic [5:0]  nu, nd, ni;
    raw_v = {bus.inside_floor, bus.outside_down, bus.outside_up};
    if (!rst_n) begin
      for (int b = 0; b < 18; b++) begin
        run_len[b] = 0;
        for (int j = 0; j < 3; j++) hist[b][j] = 0;
      end
      m_up = '0; m_down = '0; m_in = '0; m_count = '0; m_any = 0; m_changed = 0;
    end else begin
      for (int b = 0; b < 18; b++) begin
        acc[b]     = (hist[b][2] == D);
        hist[b][2] = hist[b][1];
        hist[b][1] = hist[b][0];
        run_len[b] = raw_v[b] ? ((run_len[b] < 1000) ? run_len[b] + 1 : run_len[b]) : 0;
        hist[b][0] = run_len[b];
      end
      nu = m_up; nd = m_down; ni = m_in;
      for (int f = 0; f < 6; f++) begin
        if (acc[f] && f != 5)  nu[f] = 1'b1;
        if (acc[6+f] && f != 0) nd[f] = 1'b1;
        if (acc[12+f])         ni[f] = 1'b1;
      end
      if (bus.serve_valid && bus.serve_floor < 3'd6) begin
        ni[bus.serve_floor] = 1'b0;
        if (bus.serve_dir[0]) nu[bus.serve_floor] = 1'b0;
        if (bus.serve_dir[1]) nd[bus.serve_floor] = 1'b0;
      end
      m_changed = ({nu, nd, ni} != {m_up, m_down, m_in});
      m_up = nu; m_down = nd; m_in = ni;
      m_count = 5'($countones({nu, nd, ni}));
      m_any   = (m_count != 0);
    end
  end

  function automatic logic [24:0] dut_vec();
    return {bus.queue_up, bus.queue_down, bus.queue_inside,
            bus.req_count, bus.any_request, bus.queue_changed};
  endfunction

  function automatic logic [24:0] mdl_vec();
    return {m_up, m_down, m_in, m_count, m_any, m_changed};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.outside_up   = '0;
    bus.outside_down = '0;
    bus.inside_floor = '0;
    bus.serve_valid  = 1'b0;
    bus.serve_floor  = '0;
    bus.serve_dir    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.outside_up   = 6'b010101;
    bus.inside_floor = 6'b111000;
    bus.serve_valid  = 1'b1;
    bus.serve_floor  = 3'd2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (dut_vec() !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), 25'd0);
    end
    n_tests++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", dut_vec(), mdl_vec());
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_press();
    do_reset();
    tick();
    bus.outside_up = 6'b000010;
    for (int i = 0; i < D + 2; i++) tick();
    n_tests++;
    if (bus.queue_up !== 6'b000000) begin
      n_fail++;
      $display("FAIL press_early: got %b expected %b", bus.queue_up, 6'b000000);
    end
    tick();
    n_tests++;
    if (dut_vec() !== {6'b000010, 6'b0, 6'b0, 5'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL press_accept: got %h expected %h", dut_vec(),
               {6'b000010, 6'b0, 6'b0, 5'd1, 1'b1, 1'b1});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== {6'b000010, 6'b0, 6'b0, 5'd1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL press_held cycle %0d: got %h expected %h", i, dut_vec(),
                 {6'b000010, 6'b0, 6'b0, 5'd1, 1'b1, 1'b0});
      end
    end
    clear_inputs();
  endtask

  task automatic test_short_pulse();
    do_reset();
    bus.inside_floor = 6'b001000;
    for (int i = 0; i < D - 1; i++) tick();
    bus.inside_floor = 6'b000000;
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (bus.queue_inside !== 6'b0 || bus.req_count !== 5'd0) begin
      n_fail++;
      $display("FAIL short_pulse: got inside=%b count=%0d expected inside=0 count=0",
               bus.queue_inside, bus.req_count);
    end
  endtask

  task automatic test_invalid_dir();
    do_reset();
    bus.outside_up   = 6'b100000;
    bus.outside_down = 6'b000001;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (bus.queue_up !== 6'b0 || bus.queue_down !== 6'b0 || bus.queue_changed !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_dir cycle %0d: got up=%b down=%b chg=%b expected 0 0 0",
                 i, bus.queue_up, bus.queue_down, bus.queue_changed);
      end
    end
    clear_inputs();
  endtask

  task automatic test_serve_dir();
    do_reset();
    bus.outside_up   = 6'b000100;
    bus.outside_down = 6'b000100;
    bus.inside_floor = 6'b000100;
    for (int i = 0; i < D + 3; i++) tick();
    clear_inputs();
    n_tests++;
    if ({bus.queue_up, bus.queue_down, bus.queue_inside, bus.req_count} !==
        {6'b000100, 6'b000100, 6'b000100, 5'd3}) begin
      n_fail++;
      $display("FAIL serve_setup: got %b/%b/%b count=%0d expected 000100 x3 count=3",
               bus.queue_up, bus.queue_down, bus.queue_inside, bus.req_count);
    end
    bus.serve_valid = 1'b1;
    bus.serve_floor = 3'd2;
    bus.serve_dir   = 2'b01;
    tick();
    bus.serve_valid = 1'b0;
    n_tests++;
    if (dut_vec() !== {6'b0, 6'b000100, 6'b0, 5'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL serve_up: got %h expected %h", dut_vec(),
               {6'b0, 6'b000100, 6'b0, 5'd1, 1'b1, 1'b1});
    end
    bus.serve_valid = 1'b1;
    bus.serve_dir   = 2'b10;
    tick();
    bus.serve_valid = 1'b0;
    n_tests++;
    if (dut_vec() !== {18'b0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL serve_down: got %h expected %h", dut_vec(), {18'b0, 5'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.inside_floor = 6'b010010;
    for (int i = 0; i < D + 2; i++) tick();
    bus.serve_valid = 1'b1;
    bus.serve_floor = 3'd4;
    bus.serve_dir   = 2'b00;
    tick();
    clear_inputs();
    n_tests++;
    if (bus.queue_inside !== 6'b000010 || bus.req_count !== 5'd1) begin
      n_fail++;
      $display("FAIL collision: got inside=%b count=%0d expected 000010 count=1",
               bus.queue_inside, bus.req_count);
    end
    tick();
    bus.serve_valid = 1'b1;
    bus.serve_floor = 3'd7;
    bus.serve_dir   = 2'b11;
    tick();
    bus.serve_valid = 1'b0;
    n_tests++;
    if (dut_vec() !== {6'b0, 6'b0, 6'b000010, 5'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL serve_out_of_range: got %h expected %h", dut_vec(),
               {6'b0, 6'b0, 6'b000010, 5'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_held();
    clear_inputs();
    rst_n = 1'b0;
    bus.inside_floor = 6'b000001;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < D + 2; i++) tick();
    n_tests++;
    if (bus.queue_inside !== 6'b0) begin
      n_fail++;
      $display("FAIL held_reset_early: got %b expected %b", bus.queue_inside, 6'b0);
    end
    tick();
    n_tests++;
    if (bus.queue_inside !== 6'b000001) begin
      n_fail++;
      $display("FAIL held_reset_accept: got %b expected %b", bus.queue_inside, 6'b000001);
    end
    clear_inputs();
  endtask

  task automatic test_fill();
    do_reset();
    bus.outside_up   = 6'b111111;
    bus.outside_down = 6'b111111;
    bus.inside_floor = 6'b111111;
    for (int i = 0; i < D + 3 + 5; i++) tick();
    n_tests++;
    if (dut_vec() !== {6'b011111, 6'b111110, 6'b111111, 5'd16, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_all: got %h expected %h", dut_vec(),
               {6'b011111, 6'b111110, 6'b111111, 5'd16, 1'b1, 1'b0});
    end
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (dut_vec() !== 25'd0) begin
      n_fail++;
      $display("FAIL fill_reset: got %h expected %h", dut_vec(), 25'd0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, 5) == 0) bus.outside_up[b]   = ~bus.outside_up[b];
        if ($urandom_range(0, 5) == 0) bus.outside_down[b] = ~bus.outside_down[b];
        if ($urandom_range(0, 5) == 0) bus.inside_floor[b] = ~bus.inside_floor[b];
      end
      bus.serve_valid = ($urandom_range(0, 5) == 0);
      bus.serve_floor = 3'($urandom_range(0, 7));
      bus.serve_dir   = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      n_tests++;
      if (dut_vec() !== mdl_vec() || bus.req_count > 5'd16) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_press();
    test_short_pulse();
    test_invalid_dir();
    test_serve_dir();
    test_collision();
    test_reset_held();
    test_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
